// File: rtl/rr_mem_interconnect.sv
// Round-robin memory interconnect: N_MASTERS requesters share one memory port, one transaction per grant.
// Optional busy-timeout abort enabled by defining RR_TIMEOUT_EN.
module rr_mem_interconnect #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          req,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS-1:0]          m_write,
  output logic [N_MASTERS-1:0]          gnt,
  output logic                          mem_valid,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_write,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack,
  output logic [DATA_W-1:0]             s_rdata,
  output logic [N_MASTERS-1:0]          s_ack,
  output logic [N_MASTERS-1:0]          s_err
);

  localparam int PTR_W = $clog2(N_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 mem_write_q, mem_write_d;
  logic [DATA_W-1:0]    s_rdata_q, s_rdata_d;
  logic [N_MASTERS-1:0] s_ack_q, s_ack_d;

  logic                 sel_found;
  logic [PTR_W-1:0]     sel_idx;
  int                   cand;

`ifdef RR_TIMEOUT_EN
  logic [7:0]           tmo_cnt_q, tmo_cnt_d;
  logic [N_MASTERS-1:0] s_err_q, s_err_d;
`endif

  // First requester strictly after the last granted index, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= N_MASTERS; off++) begin
      cand = (int'(ptr_q) + off) % N_MASTERS;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = mem_write_q;
    s_rdata_d   = s_rdata_q;
    s_ack_d     = s_ack_q;
`ifdef RR_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    s_err_d     = s_err_q;
`endif
    case (state_q)
      IDLE: begin
        s_ack_d   = '0;
        s_rdata_d = '0;
`ifdef RR_TIMEOUT_EN
        s_err_d   = '0;
`endif
        if (sel_found) begin
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          ptr_d          = sel_idx;
          mem_addr_d     = m_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
          mem_wdata_d    = m_wdata[int'(sel_idx)*DATA_W +: DATA_W];
          mem_write_d    = m_write[sel_idx];
          state_d        = BUSY;
`ifdef RR_TIMEOUT_EN
          tmo_cnt_d      = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ack) begin
          s_rdata_d      = mem_rdata;
          s_ack_d        = '0;
          s_ack_d[ptr_q] = 1'b1;
          gnt_d          = '0;
          mem_addr_d     = '0;
          mem_wdata_d    = '0;
          mem_write_d    = 1'b0;
          state_d        = RESP;
        end
`ifdef RR_TIMEOUT_EN
        // Expiry on the TIMEOUT-th busy cycle; a coincident mem_ack takes the branch above.
        else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
          s_rdata_d      = '0;
          s_ack_d        = '0;
          s_ack_d[ptr_q] = 1'b1;
          s_err_d        = '0;
          s_err_d[ptr_q] = 1'b1;
          gnt_d          = '0;
          mem_addr_d     = '0;
          mem_wdata_d    = '0;
          mem_write_d    = 1'b0;
          state_d        = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        s_ack_d   = '0;
        s_rdata_d = '0;
`ifdef RR_TIMEOUT_EN
        s_err_d   = '0;
`endif
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_W'(N_MASTERS - 1);
      gnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      s_rdata_q   <= '0;
      s_ack_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      s_rdata_q   <= s_rdata_d;
      s_ack_q     <= s_ack_d;
    end
  end

`ifdef RR_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      s_err_q   <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      s_err_q   <= s_err_d;
    end
  end

  assign s_err = s_err_q;
`else
  assign s_err = '0;
`endif

  assign gnt       = gnt_q;
  assign mem_valid = (state_q == BUSY);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign s_rdata   = s_rdata_q;
  assign s_ack     = s_ack_q;

endmodule
